// File: rtl/tlb_miss_sched.sv
// rtl/tlb_miss_sched.sv - ITLB/DTLB miss sequencer over the shared TLB and page-table walker
module tlb_miss_sched #(
   parameter int VLEN         = 39,
   parameter int ASID_WIDTH   = 16,
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  itlb_req_i,
   input  logic [VLEN-1:0]       itlb_vaddr_i,
   input  logic [ASID_WIDTH-1:0] itlb_asid_i,
   output logic                  itlb_gnt_o,
   input  logic                  dtlb_req_i,
   input  logic [VLEN-1:0]       dtlb_vaddr_i,
   input  logic [ASID_WIDTH-1:0] dtlb_asid_i,
   output logic                  dtlb_gnt_o,
   output logic                  stlb_lookup_o,
   output logic [VLEN-1:0]       stlb_vaddr_o,
   output logic [ASID_WIDTH-1:0] stlb_asid_o,
   output logic                  stlb_is_itlb_o,
   input  logic                  stlb_hit_i,
   output logic                  ptw_req_o,
   input  logic                  ptw_gnt_i,
   input  logic                  ptw_done_i,
   input  logic                  ptw_error_i,
   output logic                  itlb_done_o,
   output logic                  dtlb_done_o,
   output logic                  fault_o,
   output logic                  busy_o,
   output logic [CNT_WIDTH-1:0]  hit_cnt_o,
   output logic [CNT_WIDTH-1:0]  walk_cnt_o
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_CHECK,
      S_WALK,
      S_WAIT,
      S_DRAIN
   } state_e;

   state_e                  state_q, state_d;
   logic [SW-1:0]           starve_q;
   logic [VLEN-1:0]         vaddr_q;
   logic [ASID_WIDTH-1:0]   asid_q;
   logic                    is_itlb_q;
   logic                    itlb_done_q, dtlb_done_q, fault_q;
   logic [CNT_WIDTH-1:0]    hit_cnt_q, walk_cnt_q;

   logic                    starved;
   logic                    itlb_gnt, dtlb_gnt;
   logic                    hit_evt, walk_evt;
   logic                    resolve, resolve_fault;

   // ITLB is forced through once it has watched STARVE_LIMIT DTLB grants go by
   assign starved = (starve_q == SW'(STARVE_LIMIT));

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next state, arbitration and per-state strobes
   always_comb begin
      state_d       = state_q;
      itlb_gnt      = 1'b0;
      dtlb_gnt      = 1'b0;
      stlb_lookup_o = 1'b0;
      ptw_req_o     = 1'b0;
      hit_evt       = 1'b0;
      walk_evt      = 1'b0;
      resolve       = 1'b0;
      resolve_fault = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!flush_i) begin
               if (itlb_req_i && (!dtlb_req_i || starved)) begin
                  itlb_gnt = 1'b1;
                  state_d  = S_LOOKUP;
               end else if (dtlb_req_i) begin
                  dtlb_gnt = 1'b1;
                  state_d  = S_LOOKUP;
               end
            end
         end
         S_LOOKUP: begin
            stlb_lookup_o = 1'b1;
            state_d       = flush_i ? S_IDLE : S_CHECK;
         end
         S_CHECK: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else if (stlb_hit_i) begin
               hit_evt = 1'b1;
               resolve = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_WALK;
            end
         end
         S_WALK: begin
            // a flush pulls the request back so the walker never sees an accepted walk we abandon
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               ptw_req_o = 1'b1;
               if (ptw_gnt_i) begin
                  walk_evt = 1'b1;
                  state_d  = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (flush_i) begin
               state_d = ptw_done_i ? S_IDLE : S_DRAIN;
            end else if (ptw_done_i) begin
               resolve       = 1'b1;
               resolve_fault = ptw_error_i;
               state_d       = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (ptw_done_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Latch the granted miss and register the completion pulses
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vaddr_q     <= '0;
         asid_q      <= '0;
         is_itlb_q   <= 1'b0;
         itlb_done_q <= 1'b0;
         dtlb_done_q <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         if (itlb_gnt || dtlb_gnt) begin
            vaddr_q   <= itlb_gnt ? itlb_vaddr_i : dtlb_vaddr_i;
            asid_q    <= itlb_gnt ? itlb_asid_i  : dtlb_asid_i;
            is_itlb_q <= itlb_gnt;
         end
         itlb_done_q <= resolve &&  is_itlb_q;
         dtlb_done_q <= resolve && !is_itlb_q;
         fault_q     <= resolve_fault;
      end
   end

   // Starvation counter: counts DTLB wins over a waiting ITLB
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         starve_q <= '0;
      end else if (flush_i || itlb_gnt) begin
         starve_q <= '0;
      end else if (dtlb_gnt && itlb_req_i && !starved) begin
         starve_q <= starve_q + SW'(1);
      end
   end

   // Saturating perf counters, deliberately untouched by flush
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hit_cnt_q  <= '0;
         walk_cnt_q <= '0;
      end else begin
         if (hit_evt && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + CNT_WIDTH'(1);
         if (walk_evt && (walk_cnt_q != '1)) walk_cnt_q <= walk_cnt_q + CNT_WIDTH'(1);
      end
   end

   assign itlb_gnt_o     = itlb_gnt;
   assign dtlb_gnt_o     = dtlb_gnt;
   assign stlb_vaddr_o   = vaddr_q;
   assign stlb_asid_o    = asid_q;
   assign stlb_is_itlb_o = is_itlb_q;
   assign itlb_done_o    = itlb_done_q;
   assign dtlb_done_o    = dtlb_done_q;
   assign fault_o        = fault_q;
   assign busy_o         = (state_q != S_IDLE);
   assign hit_cnt_o      = hit_cnt_q;
   assign walk_cnt_o     = walk_cnt_q;

endmodule

// File: tb/tb_tlb_miss_sched.sv
// tb/tb_tlb_miss_sched.sv - self-checking bench for tlb_miss_sched
module tb_tlb_miss_sched;

   localparam int VLEN = 39;
   localparam int AW   = 16;

   logic            clk_i = 1'b0;
   logic            rst_i, flush_i;
   logic            itlb_req_i, dtlb_req_i;
   logic [VLEN-1:0] itlb_vaddr_i, dtlb_vaddr_i;
   logic [AW-1:0]   itlb_asid_i, dtlb_asid_i;
   logic            stlb_hit_i, ptw_gnt_i, ptw_done_i, ptw_error_i;

   logic            itlb_gnt_o, dtlb_gnt_o, stlb_lookup_o, stlb_is_itlb_o, ptw_req_o;
   logic [VLEN-1:0] stlb_vaddr_o;
   logic [AW-1:0]   stlb_asid_o;
   logic            itlb_done_o, dtlb_done_o, fault_o, busy_o;
   logic [15:0]     hit_cnt_o, walk_cnt_o;

   logic            s_itlb_gnt, s_dtlb_gnt, s_lookup, s_is_itlb, s_ptw_req;
   logic [VLEN-1:0] s_vaddr;
   logic [AW-1:0]   s_asid;
   logic            s_itlb_done, s_dtlb_done, s_fault, s_busy;
   logic [1:0]      s_hit_cnt, s_walk_cnt;

   int n_cmp  = 0;
   int n_fail = 0;
   int exp_hits  = 0;
   int exp_walks = 0;

   tlb_miss_sched #(.VLEN(VLEN), .ASID_WIDTH(AW), .STARVE_LIMIT(4), .CNT_WIDTH(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .itlb_req_i(itlb_req_i), .itlb_vaddr_i(itlb_vaddr_i), .itlb_asid_i(itlb_asid_i), .itlb_gnt_o(itlb_gnt_o),
      .dtlb_req_i(dtlb_req_i), .dtlb_vaddr_i(dtlb_vaddr_i), .dtlb_asid_i(dtlb_asid_i), .dtlb_gnt_o(dtlb_gnt_o),
      .stlb_lookup_o(stlb_lookup_o), .stlb_vaddr_o(stlb_vaddr_o), .stlb_asid_o(stlb_asid_o),
      .stlb_is_itlb_o(stlb_is_itlb_o), .stlb_hit_i(stlb_hit_i),
      .ptw_req_o(ptw_req_o), .ptw_gnt_i(ptw_gnt_i), .ptw_done_i(ptw_done_i), .ptw_error_i(ptw_error_i),
      .itlb_done_o(itlb_done_o), .dtlb_done_o(dtlb_done_o), .fault_o(fault_o), .busy_o(busy_o),
      .hit_cnt_o(hit_cnt_o), .walk_cnt_o(walk_cnt_o)
   );

   tlb_miss_sched #(.VLEN(VLEN), .ASID_WIDTH(AW), .STARVE_LIMIT(4), .CNT_WIDTH(2)) dut_sat (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .itlb_req_i(itlb_req_i), .itlb_vaddr_i(itlb_vaddr_i), .itlb_asid_i(itlb_asid_i), .itlb_gnt_o(s_itlb_gnt),
      .dtlb_req_i(dtlb_req_i), .dtlb_vaddr_i(dtlb_vaddr_i), .dtlb_asid_i(dtlb_asid_i), .dtlb_gnt_o(s_dtlb_gnt),
      .stlb_lookup_o(s_lookup), .stlb_vaddr_o(s_vaddr), .stlb_asid_o(s_asid),
      .stlb_is_itlb_o(s_is_itlb), .stlb_hit_i(stlb_hit_i),
      .ptw_req_o(s_ptw_req), .ptw_gnt_i(ptw_gnt_i), .ptw_done_i(ptw_done_i), .ptw_error_i(ptw_error_i),
      .itlb_done_o(s_itlb_done), .dtlb_done_o(s_dtlb_done), .fault_o(s_fault), .busy_o(s_busy),
      .hit_cnt_o(s_hit_cnt), .walk_cnt_o(s_walk_cnt)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   function automatic int sat3(input int v);
      return (v > 3) ? 3 : v;
   endfunction

   task automatic check_cnts(input string tag);
      check({tag, "_hit_cnt"},  hit_cnt_o,  exp_hits);
      check({tag, "_walk_cnt"}, walk_cnt_o, exp_walks);
      check({tag, "_sat_hit"},  s_hit_cnt,  sat3(exp_hits));
      check({tag, "_sat_walk"}, s_walk_cnt, sat3(exp_walks));
   endtask

   task automatic check_quiet_idle(input string tag);
      check({tag, "_busy"},   busy_o,      0);
      check({tag, "_idone"},  itlb_done_o, 0);
      check({tag, "_ddone"},  dtlb_done_o, 0);
      check({tag, "_fault"},  fault_o,     0);
      check({tag, "_ptwreq"}, ptw_req_o,   0);
      check_cnts(tag);
   endtask

   // One miss: fm selects flush placement 0=none 1=LOOKUP 2=CHECK 3=WALK@gnt 4=WAIT->DRAIN 5=WAIT with done
   task automatic run_miss(input bit itlb, input bit hit, input int gd, input int dd, input bit err,
                           input int fm, input logic [VLEN-1:0] va, input logic [AW-1:0] as);
      if (itlb) begin
         itlb_req_i = 1'b1; itlb_vaddr_i = va; itlb_asid_i = as;
         dtlb_vaddr_i = ~va; dtlb_asid_i = ~as;
      end else begin
         dtlb_req_i = 1'b1; dtlb_vaddr_i = va; dtlb_asid_i = as;
         itlb_vaddr_i = ~va; itlb_asid_i = ~as;
      end
      #1;
      check("gnt_itlb", itlb_gnt_o, itlb);
      check("gnt_dtlb", dtlb_gnt_o, !itlb);
      check("idle_busy", busy_o, 0);
      check("pulse_width_i", itlb_done_o, 0);
      check("pulse_width_d", dtlb_done_o, 0);
      tick();
      itlb_req_i = 1'b0; dtlb_req_i = 1'b0;
      itlb_vaddr_i = '0; dtlb_vaddr_i = '0;
      flush_i = (fm == 1);
      #1;
      check("lookup", stlb_lookup_o, 1);
      check("lk_vaddr", stlb_vaddr_o, va);
      check("lk_asid", stlb_asid_o, as);
      check("lk_is_itlb", stlb_is_itlb_o, itlb);
      check("lk_busy", busy_o, 1);
      tick();
      flush_i = 1'b0;
      if (fm == 1) begin
         #1; check_quiet_idle("flush_lookup"); tick();
         return;
      end
      stlb_hit_i = hit;
      flush_i = (fm == 2);
      #1;
      check("chk_lookup_low", stlb_lookup_o, 0);
      check("chk_busy", busy_o, 1);
      tick();
      stlb_hit_i = 1'b0; flush_i = 1'b0;
      if (fm == 2) begin
         #1; check_quiet_idle("flush_check"); tick();
         return;
      end
      if (hit) begin
         exp_hits++;
         #1;
         check("hit_idone", itlb_done_o, itlb);
         check("hit_ddone", dtlb_done_o, !itlb);
         check("hit_fault", fault_o, 0);
         check("hit_busy", busy_o, 0);
         check("hit_vaddr_stable", stlb_vaddr_o, va);
         check_cnts("hit");
         tick();
         return;
      end
      for (int k = 0; k <= gd; k++) begin
         ptw_gnt_i = (k == gd);
         flush_i = (fm == 3) && (k == gd);
         #1;
         check("walk_req", ptw_req_o, !((fm == 3) && (k == gd)));
         check("walk_busy", busy_o, 1);
         check("walk_vaddr", stlb_vaddr_o, va);
         check("walk_done", itlb_done_o | dtlb_done_o, 0);
         tick();
         ptw_gnt_i = 1'b0; flush_i = 1'b0;
      end
      if (fm == 3) begin
         #1; check_quiet_idle("flush_walk"); tick();
         return;
      end
      exp_walks++;
      for (int k = 0; k <= dd; k++) begin
         ptw_done_i = (k == dd);
         ptw_error_i = (k == dd) ? err : 1'($urandom);
         if (fm >= 4 && k == 0) flush_i = 1'b1;
         if (fm == 4 && k > 0) begin
            dtlb_req_i = 1'b1;
            flush_i = 1'($urandom);
         end
         #1;
         check("wait_req", ptw_req_o, 0);
         check("wait_busy", busy_o, 1);
         check("wait_done", itlb_done_o | dtlb_done_o, 0);
         check("wait_nogrant", dtlb_gnt_o | itlb_gnt_o, 0);
         check("wait_ptw_fields", stlb_asid_o, as);
         check("wait_walks", walk_cnt_o, exp_walks);
         tick();
         ptw_done_i = 1'b0; ptw_error_i = 1'b0; flush_i = 1'b0; dtlb_req_i = 1'b0;
      end
      if (fm >= 4) begin
         #1;
         check_quiet_idle("flush_wait");
         if (fm == 4) begin
            dtlb_req_i = 1'b1;
            #1;
            check("drain_regrant", dtlb_gnt_o, 1);
            dtlb_req_i = 1'b0;
         end
         tick();
         return;
      end
      #1;
      check("walk_idone", itlb_done_o, itlb);
      check("walk_ddone", dtlb_done_o, !itlb);
      check("walk_fault", fault_o, err);
      check("walk_end_busy", busy_o, 0);
      check("walk_vaddr_stable", stlb_vaddr_o, va);
      check_cnts("walk");
      tick();
   endtask

   initial begin
      logic [VLEN-1:0] va;
      logic [AW-1:0]   as;
      bit              prev_i, exp_i, r_itlb, r_hit, r_err;
      int              r_fm, r_gd, r_dd, sel;

      rst_i = 1'b1; flush_i = 1'b0;
      itlb_req_i = 1'b0; dtlb_req_i = 1'b0;
      itlb_vaddr_i = '0; dtlb_vaddr_i = '0; itlb_asid_i = '0; dtlb_asid_i = '0;
      stlb_hit_i = 1'b0; ptw_gnt_i = 1'b0; ptw_done_i = 1'b0; ptw_error_i = 1'b0;
      tick(); tick();
      rst_i = 1'b0;
      #1;
      check_quiet_idle("reset");
      check("reset_lookup", stlb_lookup_o, 0);
      check("reset_vaddr", stlb_vaddr_o, 0);
      check("reset_is_itlb", stlb_is_itlb_o, 0);
      tick();

      // DTLB-only miss resolved by a shared hit
      run_miss(0, 1, 0, 0, 0, 0, 39'h12345000, 16'h00a5);
      // ITLB miss through a faulting walk
      run_miss(1, 0, 2, 9, 1, 0, 39'h7f_0000_1000, 16'h1234);
      // Four more hits drive the 2-bit counter into saturation
      for (int i = 0; i < 4; i++) run_miss(i[0], 1, 0, 0, 0, 0, VLEN'({$urandom(), $urandom()}), AW'($urandom()));
      // Flush in WAIT, walk returns five cycles later
      run_miss(0, 0, 1, 5, 1, 4, 39'h55_5555_5000, 16'h0042);
      // Flush coincident with the walker accepting
      run_miss(1, 0, 1, 0, 0, 3, 39'h00_0bad_0000, 16'h0007);

      // Flush in IDLE blocks a grant
      dtlb_req_i = 1'b1; flush_i = 1'b1;
      #1;
      check("idle_flush_block", dtlb_gnt_o, 0);
      tick();
      dtlb_req_i = 1'b0; flush_i = 1'b0;
      #1; check_quiet_idle("idle_flush");
      tick();

      // Both TLBs hammering: every fifth grant goes to the ITLB
      itlb_req_i = 1'b1; dtlb_req_i = 1'b1;
      itlb_vaddr_i = 39'h1_1110_0000; dtlb_vaddr_i = 39'h2_2220_0000;
      prev_i = 1'b0;
      for (int n = 0; n < 10; n++) begin
         exp_i = ((n % 5) == 4);
         #1;
         check("starve_gnt_i", itlb_gnt_o, exp_i);
         check("starve_gnt_d", dtlb_gnt_o, !exp_i);
         if (n > 0) begin
            check("starve_prev_idone", itlb_done_o, prev_i);
            check("starve_prev_ddone", dtlb_done_o, !prev_i);
         end
         tick();
         #1;
         check("starve_is_itlb", stlb_is_itlb_o, exp_i);
         check("starve_vaddr", stlb_vaddr_o, exp_i ? 39'h1_1110_0000 : 39'h2_2220_0000);
         check("starve_busy_gnt", itlb_gnt_o | dtlb_gnt_o, 0);
         tick();
         stlb_hit_i = 1'b1;
         tick();
         stlb_hit_i = 1'b0;
         exp_hits++;
         prev_i = exp_i;
      end
      itlb_req_i = 1'b0; dtlb_req_i = 1'b0;
      #1;
      check("starve_last_idone", itlb_done_o, prev_i);
      check_cnts("starve");
      tick();

      // Randomized misses against the bench's own counters and timing rules
      for (int t = 0; t < 40; t++) begin
         r_itlb = 1'($urandom);
         r_hit  = 1'($urandom);
         r_err  = 1'($urandom);
         r_gd   = $urandom_range(0, 4);
         r_dd   = $urandom_range(0, 6);
         sel    = $urandom_range(0, 9);
         r_fm   = (sel < 5) ? 0 : sel - 4;
         if (r_fm >= 3) r_hit = 1'b0;
         if (r_fm == 4 && r_dd == 0) r_dd = 1;
         if (r_fm == 5) r_dd = 0;
         va = VLEN'({$urandom(), $urandom()});
         as = AW'($urandom());
         run_miss(r_itlb, r_hit, r_gd, r_dd, r_err, r_fm, va, as);
      end

      // Reset in the middle of a walk, then a stray walker completion
      dtlb_req_i = 1'b1; dtlb_vaddr_i = 39'h3_0000_0000;
      tick();
      dtlb_req_i = 1'b0;
      tick();
      tick();
      #1;
      check("pre_reset_walk", ptw_req_o, 1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      exp_hits = 0; exp_walks = 0;
      #1;
      check_quiet_idle("mid_reset");
      check("mid_reset_vaddr", stlb_vaddr_o, 0);
      check("mid_reset_sat_busy", s_busy, 0);
      check("mid_reset_sat_vaddr", s_vaddr, 0);
      ptw_done_i = 1'b1; ptw_error_i = 1'b1;
      tick();
      ptw_done_i = 1'b0; ptw_error_i = 1'b0;
      #1;
      check_quiet_idle("stray_done");
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/tlb_miss_sched.md
Name: tlb_miss_sched

Overview:
Sequences ITLB/DTLB misses through the shared TLB and the page-table walker (PTW). It arbitrates one miss at a time and issues a shared-TLB lookup. On a shared miss it launches a PTW walk, then signals completion to the originating TLB. It sits between both L1 TLBs, the shared_tlb lookup port and the PTW request port.

Parameters:
VLEN, 39, virtual address width
ASID_WIDTH, 16, ASID width
STARVE_LIMIT, 4, consecutive DTLB grants while ITLB waits before ITLB is forced
CNT_WIDTH, 16, width of saturating perf counters

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is synchronous and active-high
flush_i  in  1  sfence/flush request
itlb_req_i  in  1  ITLB miss pending, held until grant
itlb_vaddr_i  in  VLEN  ITLB miss address
itlb_asid_i  in  ASID_WIDTH  ITLB ASID
itlb_gnt_o  out  1  ITLB request accepted (comb, IDLE only)
dtlb_req_i  in  1  DTLB miss pending, held until grant
dtlb_vaddr_i  in  VLEN  DTLB miss address
dtlb_asid_i  in  ASID_WIDTH  DTLB ASID
dtlb_gnt_o  out  1  DTLB request accepted
stlb_lookup_o  out  1  shared-TLB lookup strobe
stlb_vaddr_o  out  VLEN  latched miss address
stlb_asid_o  out  ASID_WIDTH  latched ASID
stlb_is_itlb_o  out  1  latched requester (1=ITLB)
stlb_hit_i  in  1  shared-TLB hit, valid the cycle after the strobe
ptw_req_o  out  1  walk request
ptw_gnt_i  in  1  PTW accepted request
ptw_done_i  in  1  walk finished (1-cycle pulse)
ptw_error_i  in  1  walk fault, qualified by ptw_done_i
itlb_done_o  out  1  ITLB miss resolved (registered pulse)
dtlb_done_o  out  1  DTLB miss resolved
fault_o  out  1  done pulse carries a page fault
busy_o  out  1  state != IDLE
hit_cnt_o  out  CNT_WIDTH  shared-TLB hits, saturating
walk_cnt_o  out  CNT_WIDTH  PTW walks launched, saturating

Behaviour:
- Reset: state IDLE. All outputs, the latched vaddr/asid/is_itlb, the starvation counter and the perf counters are 0.
- States: IDLE, LOOKUP, CHECK, WALK, WAIT, DRAIN.
- IDLE:
  - A grant latches vaddr/asid/requester and moves to LOOKUP.
  - DTLB has priority by default.
  - ITLB wins if only ITLB requests, or if starve_cnt == STARVE_LIMIT.
  - starve_cnt increments on each DTLB grant while itlb_req_i=1 (saturating at STARVE_LIMIT). It clears on any ITLB grant and on flush.
  - Exactly one gnt is asserted per accept.
- LOOKUP: stlb_lookup_o=1 for exactly this cycle, then CHECK.
- CHECK:
  - stlb_hit_i=1: hit_cnt++, schedule done (fault=0), go to IDLE.
  - stlb_hit_i=0: go to WALK.
- WALK: ptw_req_o=1 and held until ptw_gnt_i. On ptw_gnt_i: walk_cnt++, go to WAIT.
- WAIT: on ptw_done_i, schedule done with fault=ptw_error_i, go to IDLE.
- Done signalling: itlb_done_o/dtlb_done_o (selected by the latched requester) and fault_o are registered. They are high exactly one cycle, the cycle after the resolving event, which is also the first IDLE cycle. A new grant may occur in that cycle.
- Latency: grant at cycle 0 → lookup at cycle 1 → check at cycle 2 → done at cycle 3 on a shared hit.
- stlb_vaddr_o, stlb_asid_o and stlb_is_itlb_o are stable from LOOKUP through the done cycle; the PTW consumes the same fields.
- Flush:
  - In IDLE it blocks any grant that cycle.
  - In LOOKUP, CHECK, or WALK before ptw_gnt_i (flush wins over a same-cycle gnt), abort to IDLE with no done pulse and ptw_req_o dropped.
  - In WAIT, go to DRAIN. If ptw_done_i arrives in the same cycle, discard it and go directly to IDLE.
  - DRAIN: busy, no grants, wait for ptw_done_i, discard the result (no done, no fault), then IDLE.
  - A flush in DRAIN has no further effect.
- Perf counters saturate at all-ones. They are not cleared by flush.
- Synchronous reset mid-walk returns to IDLE immediately. A subsequent stray ptw_done_i is ignored in IDLE.
- ptw_done_i and stlb_hit_i are ignored outside WAIT/DRAIN and CHECK respectively.

Test Plan:
- DTLB-only miss, vaddr=0x12345000, stlb_hit_i=1 in CHECK → dtlb_gnt_o at c0, stlb_lookup_o at c1, dtlb_done_o at c3, fault_o=0, hit_cnt_o=1.
- ITLB miss, shared miss, ptw_gnt_i 2 cycles after WALK entry, ptw_done_i 10 cycles later with ptw_error_i=1 → itlb_done_o=1 and fault_o=1 the next cycle, walk_cnt_o=1.
- Both requesting continuously, STARVE_LIMIT=4, all shared hits → grant order D,D,D,D,I,D,D,D,D,I.
- flush_i in WAIT, ptw_done_i 5 cycles later → DRAIN; no done pulse; no grant until the cycle after ptw_done_i; busy_o=1 throughout.
- flush_i in the same cycle as ptw_gnt_i in WALK → IDLE next cycle, walk_cnt_o unchanged, no done.
- CNT_WIDTH=2, 5 shared hits → hit_cnt_o saturates at 3; rst_i → all outputs 0.
